// File: rtl/if_id_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg_if
// Description : IF->ID pipeline-register bundle: fetch handshake, hazard
//               controls, ID-side outputs and performance counters.
// Revision    : 1.0
// ============================================================================
interface if_id_reg_if #(
    parameter int CNT_W = 16
) ();
    logic [31:0]      IF_Inst;
    logic [31:0]      IF_PC4;
    logic             IF_Valid;
    logic             IF_Ready;
    logic             Stall;
    logic             Branch;
    logic [31:0]      ID_Inst_org;
    logic [31:0]      ID_PC4;
    logic             ID_Valid;
    logic [CNT_W-1:0] Flush_Cnt;
    logic [CNT_W-1:0] Stall_Cnt;

    modport master (
        output IF_Inst, IF_PC4, IF_Valid, Stall, Branch,
        input  IF_Ready, ID_Inst_org, ID_PC4, ID_Valid, Flush_Cnt, Stall_Cnt
    );

    modport slave (
        input  IF_Inst, IF_PC4, IF_Valid, Stall, Branch,
        output IF_Ready, ID_Inst_org, ID_PC4, ID_Valid, Flush_Cnt, Stall_Cnt
    );
endinterface
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register with one-entry skid buffer, branch
//               flush, load-use stall and saturating flush/stall counters.
// Revision    : 1.0
// ============================================================================
module if_id_reg #(
    parameter int CNT_W = 16
) (
    input  wire          clk,
    input  wire          rst_n,
    if_id_reg_if.slave   bus
);

    localparam logic [0:0] c_RUN  = 1'b0;
    localparam logic [0:0] c_HOLD = 1'b1;

    logic [0:0]       r_state;
    logic [31:0]      r_skid_inst;
    logic [31:0]      r_skid_pc4;
    logic [31:0]      r_id_inst;
    logic [31:0]      r_id_pc4;
    logic             r_id_valid;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    // A fetch is only accepted while the skid buffer is empty.
    assign bus.IF_Ready    = (r_state == c_RUN);
    assign bus.ID_Inst_org = r_id_inst;
    assign bus.ID_PC4      = r_id_pc4;
    assign bus.ID_Valid    = r_id_valid;
    assign bus.Flush_Cnt   = r_flush_cnt;
    assign bus.Stall_Cnt   = r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_RUN;
            r_skid_inst <= 32'd0;
            r_skid_pc4  <= 32'd0;
            r_id_inst   <= 32'd0;
            r_id_pc4    <= 32'd0;
            r_id_valid  <= 1'b0;
        end else if (bus.Branch) begin
            r_state     <= c_RUN;
            r_skid_inst <= 32'd0;
            r_skid_pc4  <= 32'd0;
            r_id_inst   <= 32'd0;
            r_id_pc4    <= 32'd0;
            r_id_valid  <= 1'b0;
        end else if (bus.Stall) begin
            // ID holds; a fetch offered while empty is parked in the skid.
            if (r_state == c_RUN && bus.IF_Valid) begin
                r_skid_inst <= bus.IF_Inst;
                r_skid_pc4  <= bus.IF_PC4;
                r_state     <= c_HOLD;
            end
        end else if (r_state == c_HOLD) begin
            r_id_inst  <= r_skid_inst;
            r_id_pc4   <= r_skid_pc4;
            r_id_valid <= 1'b1;
            r_state    <= c_RUN;
        end else if (bus.IF_Valid) begin
            r_id_inst  <= bus.IF_Inst;
            r_id_pc4   <= bus.IF_PC4;
            r_id_valid <= 1'b1;
        end else begin
            r_id_inst  <= 32'd0;
            r_id_pc4   <= 32'd0;
            r_id_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (bus.Branch && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
            if (bus.Stall && !bus.Branch && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
